// File: rtl/run_sequencer_pkg.sv
// Shared state encoding and default configuration for run_sequencer and its bench.
package run_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_RUN      = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_PRESENT  = 3'd5,
        ST_DONE     = 3'd6
    } run_state_t;

    localparam int unsigned REQ_CYCLES_DEF   = 2;
    localparam int unsigned CNT_BITS_DEF     = 16;
    localparam logic [15:0] TIMEOUT_DEF      = 16'hFFFF;
    localparam logic [7:0]  RESULT_BASE_DEF  = 8'h00;
    localparam int unsigned RESULT_COUNT_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: synchronous clear wins over enable, stops at i_limit.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_limit
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (r_count == i_limit);

endmodule

// File: rtl/run_sequencer.sv
// Host-side run initiator: req/ack start-done handshake with the core, cycle
// counting with timeout abort, then drain of a result block onto a valid/ready stream.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int unsigned          REQ_CYCLES    = REQ_CYCLES_DEF,
    parameter int unsigned          CNT_BITS      = CNT_BITS_DEF,
    parameter logic [CNT_BITS-1:0]  TIMEOUT_LIMIT = CNT_BITS'(TIMEOUT_DEF),
    parameter logic [7:0]           RESULT_BASE   = RESULT_BASE_DEF,
    parameter int unsigned          RESULT_COUNT  = RESULT_COUNT_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                go,
    output logic                busy,
    output logic                core_req,
    input  logic                core_ack,
    output logic [CNT_BITS-1:0] cycle_count,
    output logic                run_done,
    output logic                timed_out,
    output logic                dm_rd_en,
    output logic [7:0]          dm_rd_addr,
    input  logic [7:0]          dm_rd_data,
    output logic                res_valid,
    output logic [7:0]          res_data,
    input  logic                res_ready
);

    localparam int unsigned         HOLD_BITS  = 4;
    localparam logic [CNT_BITS-1:0] LIMIT_M1   = TIMEOUT_LIMIT - 1'b1;
    localparam logic [8:0]          COUNT_W    = 9'(RESULT_COUNT);
    localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(REQ_CYCLES - 1);

    run_state_t          r_state;
    logic                r_core_req;
    logic                r_run_done;
    logic                r_timed_out;
    logic                r_dm_rd_en;
    logic [7:0]          r_dm_rd_addr;
    logic                r_res_valid;
    logic [7:0]          r_res_data;
    logic [7:0]          r_index;

    logic                w_start;
    logic                w_cnt_en;
    logic                w_cnt_at_limit;
    logic                w_hold_done;
    logic                w_timeout;
    logic                w_last;
    logic [CNT_BITS-1:0] w_cycle_count;
    logic [HOLD_BITS-1:0] w_hold_unused;

    assign w_start  = (r_state == ST_IDLE) && go;
    assign w_cnt_en = (r_state == ST_REQ) || (r_state == ST_RUN);
    // Abort on the edge where the count would reach the limit (or already sits there).
    assign w_timeout = w_cnt_at_limit || (w_cycle_count == LIMIT_M1);
    assign w_last    = (({1'b0, r_index} + 9'd1) == COUNT_W);

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_cycle_cnt (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_clear    (w_start),
        .i_enable   (w_cnt_en),
        .i_limit    (TIMEOUT_LIMIT),
        .o_count    (w_cycle_count),
        .o_at_limit (w_cnt_at_limit)
    );

    sat_counter #(
        .WIDTH (HOLD_BITS)
    ) u_hold_cnt (
        .i_clk      (clock),
        .i_rst_n    (reset_n),
        .i_clear    (w_start),
        .i_enable   (r_state == ST_REQ),
        .i_limit    (HOLD_LAST),
        .o_count    (w_hold_unused),
        .o_at_limit (w_hold_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_core_req   <= 1'b0;
            r_run_done   <= 1'b0;
            r_timed_out  <= 1'b0;
            r_dm_rd_en   <= 1'b0;
            r_dm_rd_addr <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_index      <= '0;
        end else begin
            r_dm_rd_en <= 1'b0;
            r_run_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go) begin
                        r_state     <= ST_REQ;
                        r_core_req  <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_index     <= '0;
                    end
                end
                ST_REQ: begin
                    if (w_hold_done) begin
                        r_state    <= ST_RUN;
                        r_core_req <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (core_ack) begin
                        if (RESULT_COUNT == 0) begin
                            r_state    <= ST_DONE;
                            r_run_done <= 1'b1;
                        end else begin
                            r_state      <= ST_RD_ISSUE;
                            r_dm_rd_en   <= 1'b1;
                            r_dm_rd_addr <= RESULT_BASE + r_index;
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_IDLE;
                        r_timed_out <= 1'b1;
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_res_data  <= dm_rd_data;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_index     <= r_index + 8'd1;
                        if (w_last) begin
                            r_state    <= ST_DONE;
                            r_run_done <= 1'b1;
                        end else begin
                            r_state      <= ST_RD_ISSUE;
                            r_dm_rd_en   <= 1'b1;
                            r_dm_rd_addr <= RESULT_BASE + r_index + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign core_req    = r_core_req;
    assign cycle_count = w_cycle_count;
    assign run_done    = r_run_done;
    assign timed_out   = r_timed_out;
    assign dm_rd_en    = r_dm_rd_en;
    assign dm_rd_addr  = r_dm_rd_addr;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: three instances cover default, timeout/wrap and empty-block configs.
module tb_run_sequencer;
    import run_sequencer_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n;

    logic        go_a, ack_a, busy_a, core_req_a, run_done_a, timed_out_a, dm_rd_en_a, res_valid_a, res_ready_a;
    logic [15:0] cycle_count_a;
    logic [7:0]  dm_rd_addr_a, dm_rd_data_a, res_data_a;
    logic        go_b, ack_b, busy_b, core_req_b, run_done_b, timed_out_b, dm_rd_en_b, res_valid_b, res_ready_b;
    logic [15:0] cycle_count_b;
    logic [7:0]  dm_rd_addr_b, dm_rd_data_b, res_data_b;
    logic        go_c, ack_c, busy_c, core_req_c, run_done_c, timed_out_c, dm_rd_en_c, res_valid_c, res_ready_c;
    logic [15:0] cycle_count_c;
    logic [7:0]  dm_rd_addr_c, dm_rd_data_c, res_data_c;

    logic [7:0] mem [256];
    int n_vec = 0;
    int n_bad = 0;

    run_sequencer #(.REQ_CYCLES(REQ_CYCLES_DEF), .CNT_BITS(16), .TIMEOUT_LIMIT(TIMEOUT_DEF),
                    .RESULT_BASE(RESULT_BASE_DEF), .RESULT_COUNT(RESULT_COUNT_DEF)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .go(go_a), .busy(busy_a), .core_req(core_req_a),
        .core_ack(ack_a), .cycle_count(cycle_count_a), .run_done(run_done_a), .timed_out(timed_out_a),
        .dm_rd_en(dm_rd_en_a), .dm_rd_addr(dm_rd_addr_a), .dm_rd_data(dm_rd_data_a),
        .res_valid(res_valid_a), .res_data(res_data_a), .res_ready(res_ready_a));

    run_sequencer #(.REQ_CYCLES(2), .CNT_BITS(16), .TIMEOUT_LIMIT(16'd20),
                    .RESULT_BASE(8'hFE), .RESULT_COUNT(4)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .go(go_b), .busy(busy_b), .core_req(core_req_b),
        .core_ack(ack_b), .cycle_count(cycle_count_b), .run_done(run_done_b), .timed_out(timed_out_b),
        .dm_rd_en(dm_rd_en_b), .dm_rd_addr(dm_rd_addr_b), .dm_rd_data(dm_rd_data_b),
        .res_valid(res_valid_b), .res_data(res_data_b), .res_ready(res_ready_b));

    run_sequencer #(.REQ_CYCLES(2), .CNT_BITS(16), .TIMEOUT_LIMIT(TIMEOUT_DEF),
                    .RESULT_BASE(8'h00), .RESULT_COUNT(0)) u_dut_c (
        .clock(clock), .reset_n(reset_n), .go(go_c), .busy(busy_c), .core_req(core_req_c),
        .core_ack(ack_c), .cycle_count(cycle_count_c), .run_done(run_done_c), .timed_out(timed_out_c),
        .dm_rd_en(dm_rd_en_c), .dm_rd_addr(dm_rd_addr_c), .dm_rd_data(dm_rd_data_c),
        .res_valid(res_valid_c), .res_data(res_data_c), .res_ready(res_ready_c));

    // Data-memory debug port model: one-cycle read latency.
    always @(posedge clock) begin
        if (dm_rd_en_a) dm_rd_data_a <= mem[dm_rd_addr_a];
        if (dm_rd_en_b) dm_rd_data_b <= mem[dm_rd_addr_b];
        if (dm_rd_en_c) dm_rd_data_c <= mem[dm_rd_addr_c];
    end

    int         req_cyc_a, rd_n_a, done_n_a, rd_n_b, done_n_b, rd_n_c;
    logic [7:0] addr_q_a[$], byte_q_a[$], addr_q_b[$], byte_q_b[$];

    always @(negedge clock) begin
        if (core_req_a) req_cyc_a++;
        if (dm_rd_en_a) begin rd_n_a++; addr_q_a.push_back(dm_rd_addr_a); end
        if (res_valid_a && res_ready_a) byte_q_a.push_back(res_data_a);
        if (run_done_a) done_n_a++;
        if (dm_rd_en_b) begin rd_n_b++; addr_q_b.push_back(dm_rd_addr_b); end
        if (res_valid_b && res_ready_b) byte_q_b.push_back(res_data_b);
        if (run_done_b) done_n_b++;
        if (dm_rd_en_c) rd_n_c++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clr_a();
        req_cyc_a = 0; rd_n_a = 0; done_n_a = 0;
        addr_q_a.delete(); byte_q_a.delete();
    endtask

    task automatic chk_zero(input string tag, input logic bsy, input logic req, input logic dn,
                            input logic to, input logic rde, input logic rv,
                            input logic [15:0] cnt, input logic [7:0] adr, input logic [7:0] dat);
        check({tag, "_busy"}, bsy, 0);
        check({tag, "_core_req"}, req, 0);
        check({tag, "_run_done"}, dn, 0);
        check({tag, "_timed_out"}, to, 0);
        check({tag, "_dm_rd_en"}, rde, 0);
        check({tag, "_res_valid"}, rv, 0);
        check({tag, "_cycle_count"}, cnt, 0);
        check({tag, "_dm_rd_addr"}, adr, 0);
        check({tag, "_res_data"}, dat, 0);
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] aq[$], input logic [7:0] dq[$],
                              input int n, input logic [7:0] a0, input logic [7:0] d0);
        logic [7:0] ea, ed;
        check({tag, "_n_addr"}, aq.size(), n);
        check({tag, "_n_bytes"}, dq.size(), n);
        for (int i = 0; i < n && i < aq.size(); i++) begin
            ea = a0 + 8'(i);
            check($sformatf("%s_addr%0d", tag, i), aq[i], ea);
        end
        for (int i = 0; i < n && i < dq.size(); i++) begin
            ed = d0 + 8'(i);
            check($sformatf("%s_byte%0d", tag, i), dq[i], ed);
        end
    endtask

    task automatic wait_done_a(input string tag);
        for (int i = 0; i < 200 && !run_done_a; i++) tick();
        check(tag, run_done_a, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        int busy_cyc;
        reset_n = 1'b0;
        go_a = 0; ack_a = 0; res_ready_a = 0;
        go_b = 0; ack_b = 0; res_ready_b = 0;
        go_c = 0; ack_c = 0; res_ready_c = 0;
        dm_rd_data_a = '0; dm_rd_data_b = '0; dm_rd_data_c = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h40);
        clr_a();
        rd_n_b = 0; done_n_b = 0; rd_n_c = 0;

        #12;
        chk_zero("rst_a", busy_a, core_req_a, run_done_a, timed_out_a, dm_rd_en_a, res_valid_a,
                 cycle_count_a, dm_rd_addr_a, res_data_a);
        chk_zero("rst_b", busy_b, core_req_b, run_done_b, timed_out_b, dm_rd_en_b, res_valid_b,
                 cycle_count_b, dm_rd_addr_b, res_data_b);
        chk_zero("rst_c", busy_c, core_req_c, run_done_c, timed_out_c, dm_rd_en_c, res_valid_c,
                 cycle_count_c, dm_rd_addr_c, res_data_c);
        @(negedge clock) reset_n = 1'b1;
        tick();

        // 1: basic run, ack on RUN cycle 10
        clr_a(); res_ready_a = 1;
        go_a = 1; tick(); go_a = 0;
        check("t1_req1", core_req_a, 1);
        check("t1_busy", busy_a, 1);
        tick(); check("t1_req2", core_req_a, 1);
        tick(); check("t1_run1_req", core_req_a, 0);
        tick(9); ack_a = 1; tick(); ack_a = 0;
        check("t1_count", cycle_count_a, 12);
        check("t1_first_rd", dm_rd_en_a, 1);
        wait_done_a("t1_done");
        tick();
        check("t1_busy_after", busy_a, 0);
        check("t1_done_pulse", run_done_a, 0);
        check("t1_req_cycles", req_cyc_a, 2);
        check("t1_done_count", done_n_a, 1);
        check("t1_count_frozen", cycle_count_a, 12);
        chk_stream("t1", addr_q_a, byte_q_a, 8, 8'h00, 8'h40);

        // 2: backpressure on byte 3
        clr_a(); res_ready_a = 1;
        go_a = 1; tick(); go_a = 0; tick(2);
        ack_a = 1; tick(); ack_a = 0;
        check("t2_count", cycle_count_a, 3);
        for (int i = 0; i < 100 && !(res_valid_a && res_data_a == 8'h43); i++) tick();
        res_ready_a = 0;
        check("t2_b3_seen", res_data_a, 8'h43);
        check("t2_reads_at_b3", rd_n_a, 4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", res_valid_a, 1);
            check("t2_hold_data", res_data_a, 8'h43);
            check("t2_hold_no_rd", dm_rd_en_a, 0);
        end
        check("t2_reads_held", rd_n_a, 4);
        res_ready_a = 1;
        wait_done_a("t2_done");
        tick();
        check("t2_done_count", done_n_a, 1);
        chk_stream("t2", addr_q_a, byte_q_a, 8, 8'h00, 8'h40);

        // 4: stale ack during REQ, go pulsed during RUN
        clr_a(); res_ready_a = 1; ack_a = 1;
        go_a = 1; tick(); go_a = 0;
        check("t4_req1", core_req_a, 1);
        tick(); check("t4_req2", core_req_a, 1);
        check("t4_req2_busy", busy_a, 1);
        tick(); ack_a = 0; go_a = 1;
        check("t4_run1_req", core_req_a, 0);
        tick(); go_a = 0;
        tick(); ack_a = 1; tick(); ack_a = 0;
        check("t4_count", cycle_count_a, 5);
        wait_done_a("t4_done");
        tick();
        busy_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy_a) busy_cyc++;
            tick();
        end
        check("t4_no_second_run", busy_cyc, 0);
        check("t4_req_cycles", req_cyc_a, 2);
        check("t4_done_count", done_n_a, 1);
        chk_stream("t4", addr_q_a, byte_q_a, 8, 8'h00, 8'h40);

        // 6: async reset during REQ, then during PRESENT
        clr_a(); res_ready_a = 0;
        go_a = 1; tick(); go_a = 0;
        check("t6_req_before_rst", core_req_a, 1);
        #2 reset_n = 1'b0; #1;
        check("t6_req_rst_core_req", core_req_a, 0);
        check("t6_req_rst_busy", busy_a, 0);
        @(negedge clock) reset_n = 1'b1;
        tick();
        go_a = 1; tick(); go_a = 0; tick(2);
        ack_a = 1; tick(); ack_a = 0;
        for (int i = 0; i < 20 && !res_valid_a; i++) tick();
        check("t6_present", res_valid_a, 1);
        #2 reset_n = 1'b0; #1;
        chk_zero("t6_rst", busy_a, core_req_a, run_done_a, timed_out_a, dm_rd_en_a, res_valid_a,
                 cycle_count_a, dm_rd_addr_a, res_data_a);
        @(negedge clock) reset_n = 1'b1;
        tick();
        check("t6_no_pulse", done_n_a, 0);
        clr_a(); res_ready_a = 1;
        go_a = 1; tick(); go_a = 0;
        check("t6_restart_count", cycle_count_a, 0);
        tick(2); tick(3);
        ack_a = 1; tick(); ack_a = 0;
        check("t6_count", cycle_count_a, 6);
        wait_done_a("t6_done");
        tick();
        chk_stream("t6", addr_q_a, byte_q_a, 8, 8'h00, 8'h40);

        // 3: timeout at 20 with no ack, then next go clears the flag
        res_ready_b = 1;
        go_b = 1; tick(); go_b = 0;
        busy_cyc = 0;
        for (int i = 0; i < 100 && busy_b; i++) begin
            busy_cyc++;
            tick();
        end
        check("t3_busy_cycles", busy_cyc, 20);
        check("t3_timed_out", timed_out_b, 1);
        check("t3_count", cycle_count_b, 20);
        check("t3_no_reads", rd_n_b, 0);
        check("t3_no_done", done_n_b, 0);
        tick(2);
        check("t3_sticky", timed_out_b, 1);

        // 5a: address wrap FE, FF, 00, 01
        go_b = 1; tick(); go_b = 0;
        check("t3_cleared", timed_out_b, 0);
        tick(2);
        ack_b = 1; tick(); ack_b = 0;
        check("t5_count", cycle_count_b, 3);
        for (int i = 0; i < 100 && !run_done_b; i++) tick();
        check("t5_done", run_done_b, 1);
        tick();
        check("t5_done_count", done_n_b, 1);
        check("t5_timed_out", timed_out_b, 0);
        chk_stream("t5", addr_q_b, byte_q_b, 4, 8'hFE, 8'h3E);

        // 5b: empty result block
        go_c = 1; tick(); go_c = 0;
        tick(2); tick();
        ack_c = 1; tick(); ack_c = 0;
        check("t5c_done", run_done_c, 1);
        check("t5c_count", cycle_count_c, 4);
        check("t5c_busy_done", busy_c, 1);
        tick();
        check("t5c_done_drop", run_done_c, 0);
        check("t5c_idle", busy_c, 0);
        check("t5c_no_reads", rd_n_c, 0);
        check("t5c_no_valid", res_valid_c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Host-side initiator for the processor core's req/ack start-done handshake.
- On a host `go`, it raises `core_req` to restart the core and waits for `core_ack` (program done). It counts cycles and aborts on timeout.
- On completion it drains a block of result bytes from the core's data-memory debug read port onto a valid/ready output stream.
- It sits between the host/testbench harness and the core top level.

Parameters:
- REQ_CYCLES, 2: cycles `core_req` is held high per run (1..15).
- CNT_BITS, 16: width of the cycle counter.
- TIMEOUT_LIMIT, 16'hFFFF: count value at which a run is aborted.
- RESULT_BASE, 8'h00: first data-memory address drained.
- RESULT_COUNT, 8: number of result bytes drained (0..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  start request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- core_req  out  1  start/restart request to the core.
- core_ack  in  1  core done indication.
- cycle_count  out  CNT_BITS  cycles consumed by the last/current run.
- run_done  out  1  one-cycle pulse on successful completion.
- timed_out  out  1  sticky abort flag; cleared by the next accepted go.
- dm_rd_en  out  1  data-memory debug read strobe.
- dm_rd_addr  out  8  debug read address.
- dm_rd_data  in  8  read data, valid the cycle after dm_rd_en.
- res_valid  out  1  result byte available.
- res_data  out  8  result byte.
- res_ready  in  1  downstream accepts the byte.

Behaviour:
- Reset (async, reset_n low):
  - State is IDLE.
  - All outputs are 0: core_req, busy, run_done, timed_out, dm_rd_en, res_valid, cycle_count, dm_rd_addr, res_data.
  - core_req drops combinationally-free, i.e. directly from the register reset.
  - Reset mid-run abandons the run with no pulse.
- States: IDLE, REQ, RUN, RD_ISSUE, RD_WAIT, PRESENT, DONE.
- IDLE: go=1 moves to REQ, clears cycle_count and timed_out, and loads the byte index to 0.
- REQ:
  - core_req=1 for exactly REQ_CYCLES cycles, then RUN.
  - core_ack is ignored here, since it may be stale from the previous run.
- RUN:
  - core_req=0.
  - On the k-th RUN cycle with core_ack sampled 1: go to RD_ISSUE, or to DONE if RESULT_COUNT=0. cycle_count = REQ_CYCLES + k and freezes.
  - If cycle_count reaches TIMEOUT_LIMIT with no ack: set timed_out, go to IDLE, no drain, no run_done.
  - Ack in the same cycle the limit is reached: ack wins.
- Cycle counter:
  - Increments once per cycle in REQ and RUN.
  - Saturates and never wraps.
- Drain (one outstanding read):
  - RD_ISSUE: dm_rd_en=1 for 1 cycle, dm_rd_addr = (RESULT_BASE + index) mod 256; wrap past 8'hFF is legal. Next state is RD_WAIT.
  - RD_WAIT: capture dm_rd_data into res_data, go to PRESENT.
  - PRESENT: res_valid=1. res_data is held stable until res_ready=1.
  - On the handshake: index++. If index == RESULT_COUNT go to DONE, else go to RD_ISSUE.
  - res_valid never drops without a handshake.
- DONE: run_done=1 for exactly one cycle, then IDLE.
- go while busy: ignored and not queued.
- Outputs are registered except busy, which decodes state.

Decomposition:
- Shared package definitions gets:
  - typedef enum logic [2:0] run_state_t (the seven states).
  - The run_sequencer defaults REQ_CYCLES_DEF, TIMEOUT_DEF, RESULT_BASE_DEF and RESULT_COUNT_DEF, reused by the bench.
- One sub-module: sat_counter.
  - Parameterised width.
  - Ports: clear, enable, limit; outputs count and at_limit.
  - Used for cycle_count and for the REQ_CYCLES hold timer.
- The FSM and drain datapath stay in run_sequencer.

Test Plan:
1. Basic run (REQ_CYCLES=2): pulse go; core model raises core_ack on RUN cycle 10 -> core_req high exactly 2 cycles, cycle_count=12, 8 reads at addresses 0..7 with mem[i]=i+8'h40, bytes 40..47 delivered in order, run_done one pulse, busy low after.
2. Backpressure: res_ready held low 5 cycles on byte 3 -> res_valid stays high, res_data stays 8'h43 stable, no extra dm_rd_en issued, no byte lost or duplicated.
3. Timeout: TIMEOUT_LIMIT=20, core_ack never asserted -> timed_out=1, cycle_count=20, no dm_rd_en, no run_done. The next go clears timed_out.
4. Stale ack and ignored go: core_ack held 1 during REQ and go pulsed during RUN -> REQ length unchanged, ack only honoured in RUN, only one run executes.
5. Boundaries: RESULT_BASE=8'hFE, RESULT_COUNT=4 -> addresses FE, FF, 00, 01. Separately, RESULT_COUNT=0 -> ack goes straight to run_done with no reads.
6. Async reset mid-drain: reset_n low during PRESENT -> all outputs 0 immediately, including core_req and res_valid. After release, a new go runs normally with cycle_count starting from 0.
